// File: rtl/mem_ctrl_pkg.sv
// mem_ctrl_pkg: state encoding, requester IDs and access size codes for mem_ctrl
package mem_ctrl_pkg;
  typedef enum logic [1:0] {IDLE, RD, WR, DONE} state_e;
  typedef enum logic {REQ_IF, REQ_LS} req_e;
  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;
  function automatic logic [2:0] size_len(input logic [1:0] size);
    return size == SZ_BYTE ? 3'd1 : size == SZ_HALF ? 3'd2 : 3'd4;
  endfunction
endpackage

// File: rtl/mem_ctrl.sv
// mem_ctrl: arbitrates fetch and load/store requests onto the byte-wide memory bus
module mem_ctrl
  import mem_ctrl_pkg::*;
(
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        rdy_in,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  input  logic        if_flush,
  output logic        if_done,
  output logic [31:0] if_data,
  input  logic        ls_req,
  input  logic        ls_we,
  input  logic [1:0]  ls_size,
  input  logic [31:0] ls_addr,
  input  logic [31:0] ls_wdata,
  output logic        ls_done,
  output logic [31:0] ls_rdata,
  input  logic [7:0]  ram_din,
  output logic [7:0]  ram_dout,
  output logic [31:0] ram_a,
  output logic        ram_wr
);
  state_e state_q, state_d;
  req_e id_q, id_d;
  logic [2:0] cnt_q, cnt_d, len_q, len_d, nxt;
  logic [1:0] cap_idx;
  logic [31:0] addr_q, addr_d, wdata_q, wdata_d, data_q, data_d, ram_a_q, ram_a_d;
  logic [7:0] dout_q, dout_d;
  logic wr_q, wr_d, if_done_q, if_done_d, ls_done_q, ls_done_d;
  logic ls_store;

  assign nxt = cnt_q + 3'd1;
  assign cap_idx = 2'(cnt_q - 3'd1);
  assign ls_store = ls_req && ls_we;

  always_comb begin
    state_d = state_q;
    id_d = id_q;
    cnt_d = cnt_q;
    len_d = len_q;
    addr_d = addr_q;
    wdata_d = wdata_q;
    data_d = data_q;
    ram_a_d = ram_a_q;
    dout_d = dout_q;
    wr_d = wr_q;
    if_done_d = if_done_q;
    ls_done_d = ls_done_q;
    unique case (state_q)
      IDLE: if (ls_req || (if_req && !if_flush)) begin
        id_d = ls_req ? REQ_LS : REQ_IF;
        addr_d = ls_req ? ls_addr : if_addr;
        wdata_d = ls_wdata;
        len_d = size_len(ls_req ? ls_size : SZ_WORD);
        cnt_d = 3'd0;
        data_d = 32'd0;
        ram_a_d = ls_req ? ls_addr : if_addr;
        wr_d = ls_store;
        dout_d = ls_store ? ls_wdata[7:0] : 8'h00;
        state_d = ls_store ? WR : RD;
      end
      RD: if (id_q == REQ_IF && if_flush) begin
        state_d = IDLE;
        cnt_d = 3'd0;
        ram_a_d = 32'd0;
      end else begin
        // the byte on ram_din belongs to the address issued one cycle earlier
        if (cnt_q != 3'd0) data_d[{cap_idx, 3'b000} +: 8] = ram_din;
        cnt_d = nxt;
        ram_a_d = nxt < len_q ? addr_q + 32'(nxt) : 32'd0;
        if (cnt_q == len_q) begin
          state_d = DONE;
          cnt_d = 3'd0;
          if_done_d = id_q == REQ_IF;
          ls_done_d = id_q == REQ_LS;
        end
      end
      WR: if (nxt < len_q) begin
        cnt_d = nxt;
        ram_a_d = addr_q + 32'(nxt);
        dout_d = wdata_q[{nxt[1:0], 3'b000} +: 8];
      end else begin
        state_d = DONE;
        cnt_d = 3'd0;
        ram_a_d = 32'd0;
        wr_d = 1'b0;
        dout_d = 8'h00;
        ls_done_d = 1'b1;
      end
      DONE: begin
        state_d = IDLE;
        if_done_d = 1'b0;
        ls_done_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q <= IDLE;
      id_q <= REQ_IF;
      cnt_q <= 3'd0;
      len_q <= 3'd0;
      addr_q <= 32'd0;
      wdata_q <= 32'd0;
      data_q <= 32'd0;
      ram_a_q <= 32'd0;
      dout_q <= 8'h00;
      wr_q <= 1'b0;
      if_done_q <= 1'b0;
      ls_done_q <= 1'b0;
    end else if (rdy_in) begin
      state_q <= state_d;
      id_q <= id_d;
      cnt_q <= cnt_d;
      len_q <= len_d;
      addr_q <= addr_d;
      wdata_q <= wdata_d;
      data_q <= data_d;
      ram_a_q <= ram_a_d;
      dout_q <= dout_d;
      wr_q <= wr_d;
      if_done_q <= if_done_d;
      ls_done_q <= ls_done_d;
    end
  end

  assign if_done = if_done_q;
  assign ls_done = ls_done_q;
  assign if_data = data_q;
  assign ls_rdata = data_q;
  assign ram_a = ram_a_q;
  assign ram_dout = dout_q;
  assign ram_wr = wr_q;
endmodule

// File: tb/tb_mem_ctrl.sv
// tb_mem_ctrl: randomized and directed checks of mem_ctrl against a per-transaction bus model
module tb_mem_ctrl;
  localparam int MAXC = 48;
  logic clk = 1'b0, rst = 1'b1, rdy = 1'b1;
  logic if_req = 1'b0, if_flush = 1'b0, ls_req = 1'b0, ls_we = 1'b0;
  logic [31:0] if_addr = 32'd0, ls_addr = 32'd0, ls_wdata = 32'd0;
  logic [1:0] ls_size = 2'd0;
  logic if_done, ls_done, ram_wr;
  logic [31:0] if_data, ls_rdata, ram_a;
  logic [7:0] ram_din = 8'h00, ram_dout;
  int errs = 0, checks = 0;
  bit [7:0] bus_mem [4096];
  bit written [4096];
  bit [7:0] ref_mem [4096];
  bit rdy_pat [MAXC];
  bit flush_pat [MAXC];
  logic [31:0] ea [MAXC], la [MAXC], lifdata [MAXC], llsdata [MAXC];
  logic [7:0] edout [MAXC], ldout [MAXC];
  bit ewr [MAXC], eifd [MAXC], elsd [MAXC], lwr [MAXC], lifd [MAXC], llsd [MAXC];
  int if_go, ls_go, if_stop, ls_stop, rst_at;

  mem_ctrl dut (
    .clk_in(clk), .rst_in(rst), .rdy_in(rdy),
    .if_req(if_req), .if_addr(if_addr), .if_flush(if_flush), .if_done(if_done), .if_data(if_data),
    .ls_req(ls_req), .ls_we(ls_we), .ls_size(ls_size), .ls_addr(ls_addr), .ls_wdata(ls_wdata),
    .ls_done(ls_done), .ls_rdata(ls_rdata),
    .ram_din(ram_din), .ram_dout(ram_dout), .ram_a(ram_a), .ram_wr(ram_wr)
  );

  always #5 clk = ~clk;

  function automatic bit [7:0] init_byte(bit [11:0] a);
    return a == 12'h100 ? 8'h11 : a == 12'h101 ? 8'h22 : a == 12'h102 ? 8'h33 :
           a == 12'h103 ? 8'h44 : 8'((a * 12'd37) ^ (a >> 3));
  endfunction

  // one-cycle read latency bus; pauses with rdy like the real bus
  always @(posedge clk) if (rdy) begin
    ram_din <= written[ram_a[11:0]] ? bus_mem[ram_a[11:0]] : init_byte(ram_a[11:0]);
    if (ram_wr) begin
      bus_mem[ram_a[11:0]] <= ram_dout;
      written[ram_a[11:0]] <= 1'b1;
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic clear_exp();
    for (int c = 0; c < MAXC; c++) begin
      ea[c] = 32'd0; edout[c] = 8'h00; ewr[c] = 1'b0; eifd[c] = 1'b0; elsd[c] = 1'b0;
      rdy_pat[c] = 1'b1; flush_pat[c] = 1'b0;
    end
    if_go = -1; ls_go = -1; if_stop = -1; ls_stop = -1; rst_at = -1;
  endtask

  task automatic clear_from(input int c0);
    for (int c = c0; c < MAXC; c++) begin
      ea[c] = 32'd0; edout[c] = 8'h00; ewr[c] = 1'b0; eifd[c] = 1'b0; elsd[c] = 1'b0;
    end
  endtask

  // Expected bus activity of one transaction whose request is sampled from cycle go on:
  // logical step -1 is the sampling cycle, steps 0..n-1 carry bytes, done follows
  // one step later for stores and two for loads; each step advances only on rdy.
  task automatic plan(input int go, input bit is_if, input bit we, input int n,
                      input logic [31:0] addr, input logic [31:0] wdata,
                      output int done_c, output logic [31:0] rdata);
    int j, last;
    logic [31:0] ak;
    j = -1;
    last = we ? n : n + 1;
    rdata = 32'd0;
    done_c = -1;
    for (int k = 0; k < n; k++) begin
      ak = addr + 32'(k);
      if (we) ref_mem[ak[11:0]] = wdata[8*k +: 8];
      else rdata[8*k +: 8] = ref_mem[ak[11:0]];
    end
    for (int c = go; c < MAXC && j <= last; c++) begin
      if (j >= 0 && j < n) begin
        ea[c] = addr + 32'(j);
        ewr[c] = we;
        edout[c] = we ? wdata[8*j +: 8] : 8'h00;
      end
      if (j == last) begin
        done_c = c;
        if (is_if) eifd[c] = 1'b1; else elsd[c] = 1'b1;
      end
      if (rdy_pat[c]) j++;
    end
  endtask

  task automatic run();
    for (int c = 0; c < MAXC; c++) begin
      rst = (c == rst_at);
      rdy = rdy_pat[c];
      if_flush = flush_pat[c];
      if (c == if_go) if_req = 1'b1;
      if (c == ls_go) ls_req = 1'b1;
      if (c == if_stop) if_req = 1'b0;
      if (c == ls_stop) ls_req = 1'b0;
      @(negedge clk);
      la[c] = ram_a; ldout[c] = ram_dout; lwr[c] = ram_wr;
      lifd[c] = if_done; llsd[c] = ls_done; lifdata[c] = if_data; llsdata[c] = ls_rdata;
      if (if_done) if_req = 1'b0;
      if (ls_done) ls_req = 1'b0;
      @(posedge clk);
      #1;
    end
    rst = 1'b0; rdy = 1'b1; if_flush = 1'b0; if_req = 1'b0; ls_req = 1'b0;
  endtask

  task automatic compare(input string tag);
    int bad;
    bad = 0;
    for (int c = 0; c < MAXC; c++)
      if (la[c] !== ea[c] || ldout[c] !== edout[c] || lwr[c] !== ewr[c] ||
          lifd[c] !== eifd[c] || llsd[c] !== elsd[c]) bad++;
    chk({tag, "_bus_bad_cycles"}, bad, 0);
  endtask

  task automatic check_data(input string tag, input bit is_if, input int d, input logic [31:0] rd);
    if (d >= 0) chk({tag, "_data"}, is_if ? lifdata[d] : llsdata[d], rd);
  endtask

  function automatic int first_done(input bit is_if);
    for (int c = 0; c < MAXC; c++) if (is_if ? lifd[c] : llsd[c]) return c;
    return -1;
  endfunction

  initial begin
    int d, d2, wrn;
    logic [31:0] rd, rd2, w;
    for (int i = 0; i < 4096; i++) ref_mem[i] = init_byte(12'(i));
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_ram_a", ram_a, 32'd0);
    chk("rst_ram_wr", ram_wr, 1'b0);
    chk("rst_ram_dout", ram_dout, 8'h00);
    chk("rst_if_done", if_done, 1'b0);
    chk("rst_ls_done", ls_done, 1'b0);
    chk("rst_if_data", if_data, 32'd0);
    chk("rst_ls_rdata", ls_rdata, 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    clear_exp();
    if_addr = 32'h100; if_go = 0;
    plan(0, 1'b1, 1'b0, 4, 32'h100, 32'd0, d, rd);
    run();
    compare("fetch");
    chk("fetch_lat", first_done(1'b1), 6);
    if (d >= 0) chk("fetch_word", lifdata[d], 32'h4433_2211);

    clear_exp();
    ls_addr = 32'h0003_0000; ls_we = 1'b1; ls_size = 2'b00; ls_wdata = 32'h41; ls_go = 0;
    plan(0, 1'b0, 1'b1, 1, 32'h0003_0000, 32'h41, d, rd);
    run();
    compare("io_store");
    chk("io_lat", first_done(1'b0), 2);
    wrn = 0;
    for (int c = 0; c < MAXC; c++) wrn += int'(lwr[c]);
    chk("io_wr_cycles", wrn, 1);

    clear_exp();
    ls_addr = 32'h200; ls_we = 1'b0; ls_size = 2'b10; ls_go = 0;
    if_addr = 32'h300; if_go = 0;
    plan(0, 1'b0, 1'b0, 4, 32'h200, 32'd0, d, rd);
    plan(d + 1, 1'b1, 1'b0, 4, 32'h300, 32'd0, d2, rd2);
    run();
    compare("prio");
    check_data("prio_ls", 1'b0, d, rd);
    check_data("prio_if", 1'b1, d2, rd2);
    chk("prio_ls_lat", first_done(1'b0), 6);
    chk("prio_if_lat", first_done(1'b1), 13);

    clear_exp();
    ls_addr = 32'h205; ls_we = 1'b0; ls_size = 2'b10; ls_go = 0;
    for (int c = 3; c < 6; c++) rdy_pat[c] = 1'b0;
    plan(0, 1'b0, 1'b0, 4, 32'h205, 32'd0, d, rd);
    run();
    compare("stall");
    check_data("stall", 1'b0, d, rd);
    chk("stall_lat", first_done(1'b0), 9);

    clear_exp();
    w = $urandom;
    if_addr = 32'h180; if_go = 0; if_stop = 3; flush_pat[2] = 1'b1;
    ls_addr = 32'h600; ls_we = 1'b1; ls_size = 2'b00; ls_wdata = w; ls_go = 2;
    plan(0, 1'b1, 1'b0, 4, 32'h180, 32'd0, d, rd);
    clear_from(3);
    plan(3, 1'b0, 1'b1, 1, 32'h600, w, d, rd);
    run();
    compare("flush");
    chk("flush_if_done", first_done(1'b1), -1);
    chk("flush_store_lat", first_done(1'b0), 5);

    clear_exp();
    w = $urandom;
    ls_addr = 32'hF00; ls_we = 1'b1; ls_size = 2'b10; ls_wdata = w; ls_go = 0;
    rst_at = 2; ls_stop = 2;
    plan(0, 1'b0, 1'b1, 4, 32'hF00, w, d, rd);
    clear_from(3);
    run();
    compare("rst_mid");
    chk("rst_mid_done", first_done(1'b0), -1);
    chk("rst_mid_rdata", llsdata[3], 32'd0);

    clear_exp();
    ls_addr = 32'hFFFF_FFFE; ls_we = 1'b0; ls_size = 2'b11; ls_go = 0;
    plan(0, 1'b0, 1'b0, 4, 32'hFFFF_FFFE, 32'd0, d, rd);
    run();
    compare("wrap");
    check_data("wrap", 1'b0, d, rd);

    for (int t = 0; t < 40; t++) begin
      bit is_if, we;
      int n;
      logic [31:0] a;
      clear_exp();
      is_if = ($urandom_range(0, 3) == 0);
      we = !is_if && ($urandom_range(0, 1) == 1);
      ls_size = 2'($urandom_range(0, 3));
      n = is_if ? 4 : ls_size == 2'd0 ? 1 : ls_size == 2'd1 ? 2 : 4;
      a = 32'h400 + 32'($urandom_range(0, 31));
      w = $urandom;
      for (int c = 1; c < 13; c++) rdy_pat[c] = ($urandom_range(0, 3) != 0);
      if (is_if) begin
        if_addr = a; if_go = 0;
      end else begin
        ls_addr = a; ls_we = we; ls_wdata = w; ls_go = 0;
      end
      plan(0, is_if, we, n, a, w, d, rd);
      run();
      compare("rand");
      if (!we) check_data("rand", is_if, d, rd);
    end

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule

// File: doc/mem_ctrl.md
# mem_ctrl

Sequencer and arbiter for the CPU's single byte-wide memory/IO bus. It serves two requesters: instruction fetch (32-bit word reads) and the MEM stage (1/2/4-byte loads and stores). Each request is broken into consecutive byte accesses with the bus's read latency honoured, and the result is returned as one 32-bit little-endian word. It sits between the pipeline (`pc_reg`/`if_id` and `mem`) and the top-level `mem_*` pins of `cpu`.

## Interface

Parameters: none.

Ports:
- Clocking and reset (already decided): one clock, `clk_in`; reset `rst_in`, synchronous, active-high.
- `clk_in` in 1: system clock.
- `rst_in` in 1: synchronous active-high reset.
- `rdy_in` in 1: low freezes all internal state.
- `if_req` in 1: fetch request, level, held until `if_done`.
- `if_addr` in 32: fetch address.
- `if_flush` in 1: abort any queued or active fetch.
- `if_done` out 1: one-cycle pulse, fetch data valid.
- `if_data` out 32: fetched word.
- `ls_req` in 1: MEM-stage request, level, held until `ls_done`.
- `ls_we` in 1: 1 = store, 0 = load.
- `ls_size` in 2: 00 = byte, 01 = half, 10 = word; 11 is treated as word.
- `ls_addr` in 32: byte address.
- `ls_wdata` in 32: store data, little-endian.
- `ls_done` out 1: one-cycle pulse, transaction complete.
- `ls_rdata` out 32: load data, zero-extended; the MEM stage does sign extension.
- `ram_din` in 8: bus read data.
- `ram_dout` out 8: bus write data.
- `ram_a` out 32: bus address.
- `ram_wr` out 1: 1 = write.

## Operation

- **States:** IDLE, RD, WR, DONE. Byte counter `cnt` is 3 bits; length `n` is 1, 2 or 4.
- **IDLE:**
  - Samples requests at every enabled edge.
  - If `ls_req` is high, it is accepted. The MEM stage has fixed priority over fetch.
  - Otherwise `if_req` with `!if_flush` is accepted.
  - On acceptance: address, data, size and requester ID are latched; state goes to RD or WR.
- **RD:**
  - Byte k address (`addr+k`, 32-bit wrap) is driven in cycle ck, for k = 0..n-1.
  - `ram_din` is captured in cycle ck+1 into result byte k.
  - Exactly n addresses are issued and no extra byte is ever read. This matters because reads at 0x30000 have side effects.
- **WR:** byte k = `wdata[8k+7:8k]` is driven with `ram_wr`=1 in cycle ck, for k = 0..n-1.
- **DONE:**
  - Lasts one cycle. The matching done output is high and the data output is valid.
  - No request is sampled in this cycle; the state returns to IDLE at the next edge.
  - The requester must drop its request at the edge ending the DONE cycle.
- **Idle bus:** outside active byte cycles, `ram_a`=0, `ram_wr`=0 and `ram_dout`=0. The address must never park in the IO range.
- **Alignment:** misaligned addresses are permitted and handled byte-wise. Result bytes that are not read are 0.
- **`if_flush`:**
  - During an active fetch, RD is abandoned at the next edge and the state goes to IDLE.
  - No `if_done` is produced and `ram_a` returns to 0.
  - A flush has no effect on an MEM-stage transaction.
- **Simultaneous requests:** `ls_req` and `if_req` both high in IDLE → the MEM stage is served first. The fetch is accepted in the IDLE cycle after that transaction's DONE.

## Timing

- **Cycle reference:** E0 is the edge that accepts a request; cycle ck follows edge Ek.
- **Reads:**
  - Address for byte k is in cycle ck; the byte is captured at edge Ek+2.
  - Done is high in cycle cn+1: c2 for a byte, c3 for a half, c5 for a word.
- **Writes:** bytes go out in c0..cn-1; done is high in cycle cn (c1 for a byte, c4 for a word).
- **Back-to-back:** minimum 2 cycles between transactions (the DONE cycle plus one IDLE sampling cycle).
- **`rdy_in` low:**
  - All registers hold, including state, `cnt`, outputs and captured bytes.
  - The bus is paused externally, so latency stretches by exactly the number of low cycles.
  - Captures are suppressed while `rdy_in` is low.
- **Reset:**
  - Applies at any time, including mid-transaction.
  - At the next edge: state IDLE, `cnt`=0, all outputs 0 (`ram_wr`=0, `if_done`=`ls_done`=0, data outputs 0).
  - Any partial transaction is discarded silently.
- **Output registering:** all outputs are registered. The only combinational path is `ram_din` into the capture registers.

## Structure

- Shared constants belong in `defines.v` under existing `define` style: size codes (byte, half, word), state encodings and the IO base 0x30000.
- Single module `mem_ctrl`; no sub-module is warranted.
- Instantiated in `cpu`, replacing the direct `assign mem_a = pc` and `assign mem_wr = 0`.

## Test plan

- **Word fetch:** fetch at 0x100 with memory bytes 11 22 33 44 → `ram_a` = 0x100..0x103 in c0..c3; `if_done` in c5 with `if_data`=0x44332211.
- **IO byte store:** store at 0x30000 with `ls_wdata`=0x41 → exactly one cycle with `ram_wr`=1, `ram_a`=0x30000, `ram_dout`=0x41; `ls_done` in c1.
- **Priority:** `if_req` and `ls_req` (word load at 0x200) both rise together → the load completes first; the fetch begins the cycle after `ls_done`.
- **Stall:** `rdy_in` held low for 3 cycles during c2 of a word load → `ls_done` arrives 3 cycles late and `ls_rdata` is correct.
- **Flush:** `if_flush` asserted in c1 of a fetch → no `if_done`, state IDLE; a pending store is accepted at the next IDLE edge.
- **Reset mid-store:** `rst_in` asserted during c1 of a word store → `ram_wr`=0 and `ram_a`=0 from the next cycle; no done pulse.
